// File: rtl/mem_stage.sv
// Load/store stage: drives a req/gnt/rvalid bus and stalls upstream until rvalid (best case 1 stall cycle).
// Build option MISALIGN_EXP_EN turns misaligned half/word accesses into exceptions instead of bus requests.
module mem_stage #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  input  logic [XLEN-1:0]          mem_pc_i,
  input  logic                     mem_re,
  input  logic                     mem_we,
  input  logic [XLEN-1:0]          mem_ls_addr,
  input  logic [4:0]               mem_l_mask,
  input  logic [3:0]               mem_byte_we,
  input  logic [XLEN-1:0]          mem_rs2,
  input  logic                     mem_req_rf_i,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr_i,
  input  logic [XLEN-1:0]          mem_alu_res,
  input  logic                     mem_int_flag_i,
  input  logic                     mem_exp_flag_i,
  input  logic                     wb_exp_int_flag,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [XLEN-1:0]          dbus_addr,
  output logic [3:0]               dbus_be,
  output logic [XLEN-1:0]          dbus_wdata,
  input  logic                     dbus_gnt,
  input  logic                     dbus_rvalid,
  input  logic [XLEN-1:0]          dbus_rdata,
  output logic                     mem_stall,
  output logic                     mem_req_rf_o,
  output logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr_o,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [RF_ADDR_WIDTH-1:0] mem_fw_rd_addr,
  output logic [XLEN-1:0]          mem_fw_data,
  output logic                     mem_exp_int_flag,
  output logic                     mem_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nxt;
  logic            ok, start, kill_q, misalign;
  logic [XLEN-1:0] rdata_q, sh, load_data;

`ifdef MISALIGN_EXP_EN
  logic [3:0] size_sel;
  logic       is_half, is_word;
  assign size_sel = mem_re ? mem_l_mask[3:0] : mem_byte_we;
  assign is_half  = (size_sel == 4'b0011) | (~mem_re & (size_sel == 4'b1100));
  assign is_word  = (size_sel == 4'b1111);
  assign misalign = mem_valid & (mem_re | mem_we) &
                    ((is_half & mem_ls_addr[0]) | (is_word & (mem_ls_addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign mem_misalign     = misalign;
  assign mem_exp_int_flag = mem_int_flag_i | mem_exp_flag_i | misalign;
  assign ok               = ~(mem_exp_int_flag | wb_exp_int_flag);
  // Reset gates the combinational launch so an access in flight is abandoned immediately.
  assign start            = ~rst & mem_valid & (mem_re | mem_we) & ok & (state == IDLE);

  always_comb begin
    state_nxt = state;
    dbus_req  = 1'b0;
    case (state)
      IDLE: begin
        dbus_req = start;
        if (start) state_nxt = dbus_gnt ? WAIT : REQ;
      end
      REQ: begin
        if (!ok) begin
          state_nxt = IDLE;
        end else begin
          dbus_req = 1'b1;
          if (dbus_gnt) state_nxt = WAIT;
        end
      end
      WAIT:    if (dbus_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // kill_q remembers a kill seen while waiting so the late response is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      kill_q <= (state == WAIT) & ~dbus_rvalid & (kill_q | ~ok);
      if (dbus_rvalid) rdata_q <= dbus_rdata;
    end
  end

  assign mem_stall = start | (state == REQ) | ((state == WAIT) & ~dbus_rvalid);

  assign dbus_we   = mem_we;
  assign dbus_addr = {mem_ls_addr[XLEN-1:2], 2'b00};
  assign dbus_be   = mem_byte_we;

  always_comb begin
    dbus_wdata = mem_rs2;
    case (mem_byte_we)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: dbus_wdata = {4{mem_rs2[7:0]}};
      4'b0011, 4'b1100:                   dbus_wdata = {2{mem_rs2[15:0]}};
      default:                            dbus_wdata = mem_rs2;
    endcase
  end

  assign sh = dbus_rdata >> {mem_ls_addr[1:0], 3'b000};

  always_comb begin
    load_data = sh;
    case (mem_l_mask[3:0])
      4'b0001: load_data = {{24{mem_l_mask[4] & sh[7]}}, sh[7:0]};
      4'b0011: load_data = {{16{mem_l_mask[4] & sh[15]}}, sh[15:0]};
      default: load_data = sh;
    endcase
  end

  assign mem_wdata      = mem_re ? load_data : mem_alu_res;
  assign mem_req_rf_o   = ~rst & mem_req_rf_i & mem_valid & ok & ~mem_stall & ~kill_q;
  assign mem_rf_waddr_o = mem_rf_waddr_i;
  assign mem_fw_rd_addr = mem_rf_waddr_i;
  assign mem_fw_data    = mem_wdata;

  // rdata_q is a trace tap and the PC rides along for debug; neither feeds logic here.
  logic unused_dbg;
  assign unused_dbg = ^{rdata_q, mem_pc_i};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scripted bus timelines per instruction, expectations from a behavioural model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_re, mem_we, mem_req_rf_i, mem_int_flag_i, mem_exp_flag_i, wb_exp_int_flag;
  logic [31:0] mem_pc_i, mem_ls_addr, mem_rs2, mem_alu_res, dbus_rdata;
  logic [4:0]  mem_l_mask, mem_rf_waddr_i;
  logic [3:0]  mem_byte_we;
  logic        dbus_gnt, dbus_rvalid;
  logic        dbus_req, dbus_we, mem_stall, mem_req_rf_o, mem_exp_int_flag, mem_misalign;
  logic [31:0] dbus_addr, dbus_wdata, mem_wdata, mem_fw_data;
  logic [3:0]  dbus_be;
  logic [4:0]  mem_rf_waddr_o, mem_fw_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        re, we, req_rf, intf, expf;
    logic [31:0] addr, rs2, alu, rdata, exp_rd, exp_st;
    logic [4:0]  mask, rd;
    logic [3:0]  be;
    int          g, r, k;
  } instr_t;

  logic        exp_on = 1'b0;
  logic        e_req, e_we, e_stall, e_rf, e_flag, e_mis;
  logic [31:0] e_addr, e_st, e_rdv;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;

  mem_stage dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc_i(mem_pc_i), .mem_re(mem_re), .mem_we(mem_we),
    .mem_ls_addr(mem_ls_addr), .mem_l_mask(mem_l_mask), .mem_byte_we(mem_byte_we), .mem_rs2(mem_rs2),
    .mem_req_rf_i(mem_req_rf_i), .mem_rf_waddr_i(mem_rf_waddr_i), .mem_alu_res(mem_alu_res),
    .mem_int_flag_i(mem_int_flag_i), .mem_exp_flag_i(mem_exp_flag_i), .wb_exp_int_flag(wb_exp_int_flag),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
    .mem_req_rf_o(mem_req_rf_o), .mem_rf_waddr_o(mem_rf_waddr_o), .mem_wdata(mem_wdata),
    .mem_fw_rd_addr(mem_fw_rd_addr), .mem_fw_data(mem_fw_data), .mem_exp_int_flag(mem_exp_int_flag),
    .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] load_model(logic [31:0] d, logic [31:0] a, logic [4:0] m);
    int          w;
    logic [31:0] v;
    w = (m[3:0] == 4'b0001) ? 8 : (m[3:0] == 4'b0011) ? 16 : 32;
    v = d >> (8 * a[1:0]);
    if (w < 32) begin
      v = v % (32'd1 << w);
      if (m[4] && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    end
    return v;
  endfunction

  function automatic logic [31:0] store_model(logic [31:0] d, logic [3:0] be);
    case ($countones(be))
      1:       return 32'(d[7:0]) * 32'h0101_0101;
      2:       return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic mis_model(instr_t t);
`ifdef MISALIGN_EXP_EN
    int nbytes;
    nbytes = t.re ? ((t.mask[3:0] == 4'b0001) ? 1 : (t.mask[3:0] == 4'b0011) ? 2 : 4) : $countones(t.be);
    return (t.re | t.we) && ((nbytes == 2 && t.addr[0]) || (nbytes == 4 && t.addr[1:0] != 2'b00));
`else
    return 1'b0 & t.re;
`endif
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t = '0;
    t.mask = 5'b01111; t.be = 4'b1111; t.rd = 5'd1;
    t.g = 0; t.r = 1; t.k = -1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("dbus_req", 32'(dbus_req), 32'(e_req));
      chk("mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("mem_req_rf_o", 32'(mem_req_rf_o), 32'(e_rf));
      chk("mem_exp_int_flag", 32'(mem_exp_int_flag), 32'(e_flag));
      chk("mem_misalign", 32'(mem_misalign), 32'(e_mis));
      if (e_req) begin
        chk("dbus_we", 32'(dbus_we), 32'(e_we));
        chk("dbus_addr", dbus_addr, e_addr);
        chk("dbus_be", 32'(dbus_be), 32'(e_be));
        if (e_we) chk("dbus_wdata", dbus_wdata, e_st);
      end
      if (e_rf) begin
        chk("mem_rf_waddr_o", 32'(mem_rf_waddr_o), 32'(e_rd));
        chk("mem_fw_rd_addr", 32'(mem_fw_rd_addr), 32'(e_rd));
        chk("mem_wdata", mem_wdata, e_rdv);
        chk("mem_fw_data", mem_fw_data, e_rdv);
      end
    end
  end

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input instr_t t, input logic v, input logic gnt, input logic rv, input logic wb);
    mem_valid = v;        mem_re = t.re;          mem_we = t.we;         mem_ls_addr = t.addr;
    mem_l_mask = t.mask;  mem_byte_we = t.be;     mem_rs2 = t.rs2;       mem_req_rf_i = t.req_rf;
    mem_rf_waddr_i = t.rd; mem_alu_res = t.alu;   mem_int_flag_i = t.intf; mem_exp_flag_i = t.expf;
    mem_pc_i = $urandom;  dbus_rdata = t.rdata;   dbus_gnt = gnt;        dbus_rvalid = rv;
    wb_exp_int_flag = wb;
    e_we = t.we; e_addr = t.addr & ~32'd3; e_be = t.be; e_st = t.exp_st; e_rd = t.rd; e_rdv = t.exp_rd;
  endtask

  task automatic expect_quiet();
    e_req = 1'b0; e_stall = 1'b0; e_rf = 1'b0; e_flag = 1'b0; e_mis = 1'b0;
  endtask

  task automatic run_idle();
    instr_t t;
    t = blank();
    t.re = 1'($urandom); t.we = 1'($urandom); t.req_rf = 1'b1; t.addr = $urandom;
    cyc_begin();
    apply(t, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_quiet();
    exp_on = 1'b1;
  endtask

  task automatic run_instr(input instr_t t);
    logic mis, flag, req_kill;
    int   last;
    mis      = mis_model(t);
    flag     = t.intf | t.expf | mis;
    req_kill = (t.k >= 1) && (t.k <= t.g);
    if (!(t.re | t.we) || flag) begin
      cyc_begin();
      apply(t, 1'b1, 1'b0, 1'b0, 1'b0);
      e_req = 1'b0; e_stall = 1'b0; e_rf = t.req_rf & ~flag; e_flag = flag; e_mis = mis;
      if (!t.re) e_rdv = t.alu;
      exp_on = 1'b1;
    end else begin
      last = req_kill ? t.k : t.g + t.r;
      for (int c = 0; c <= last; c++) begin
        cyc_begin();
        apply(t, 1'b1, !req_kill && c == t.g, c == t.g + t.r, c == t.k);
        e_flag = 1'b0; e_mis = 1'b0;
        if (req_kill && c == t.k) begin
          e_req = 1'b0; e_stall = 1'b1; e_rf = 1'b0;
        end else begin
          e_req   = (c <= t.g);
          e_stall = (c < t.g + t.r);
          e_rf    = (c == t.g + t.r) && t.req_rf && !(t.k >= 0 && t.k < c);
        end
        exp_on = 1'b1;
      end
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    int     kind, sz;
    t = blank();
    kind = $urandom_range(0, 2);
    sz   = $urandom_range(0, 2);
    t.addr = $urandom; t.rs2 = $urandom; t.alu = $urandom; t.rdata = $urandom;
    t.rd = 5'($urandom); t.mask = {1'($urandom), (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111};
    t.g = $urandom_range(0, 3); t.r = $urandom_range(1, 3);
    t.intf = ($urandom_range(0, 9) == 0); t.expf = ($urandom_range(0, 14) == 0);
    if (kind == 0) begin
      t.re = 1'b1; t.req_rf = 1'b1;
    end else if (kind == 1) begin
      t.we = 1'b1;
      t.be = (sz == 0) ? (4'b0001 << t.addr[1:0]) : (sz == 1) ? (t.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end else begin
      t.req_rf = 1'($urandom);
    end
    if ($urandom_range(0, 5) == 0) begin
      if ($urandom_range(0, 1) == 1 && t.g >= 1) t.k = $urandom_range(1, t.g);
      else if (t.r >= 2)                         t.k = $urandom_range(t.g + 1, t.g + t.r - 1);
    end
    t.exp_rd = t.re ? load_model(t.rdata, t.addr, t.mask) : t.alu;
    t.exp_st = store_model(t.rs2, t.be);
    return t;
  endfunction

  initial begin
    instr_t t;
    rst = 1'b1;
    t = blank();
    apply(t, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_quiet();
    cyc_begin();
    exp_on = 1'b1;
    cyc_begin();
    rst = 1'b0;

    // lb 0x1003: sign-extended top byte, one stall cycle
    t = blank(); t.re = 1'b1; t.addr = 32'h0000_1003; t.mask = 5'b10001; t.rdata = 32'h80FF_1234;
    t.req_rf = 1'b1; t.rd = 5'd3; t.exp_rd = 32'hFFFF_FF80;
    run_instr(t);
    // lhu 0x2002
    t = blank(); t.re = 1'b1; t.addr = 32'h0000_2002; t.mask = 5'b00011; t.rdata = 32'hBEEF_0000;
    t.req_rf = 1'b1; t.rd = 5'd4; t.exp_rd = 32'h0000_BEEF;
    run_instr(t);
    // sb 0x3001 with grant delayed three cycles
    t = blank(); t.we = 1'b1; t.addr = 32'h0000_3001; t.be = 4'b0010; t.rs2 = 32'h1234_56AB;
    t.exp_st = 32'hABAB_ABAB; t.g = 3; t.r = 1;
    run_instr(t);
    // lw killed while requesting, then killed while waiting
    t = blank(); t.re = 1'b1; t.addr = 32'h0000_0040; t.rdata = 32'h1111_2222; t.req_rf = 1'b1;
    t.exp_rd = 32'h1111_2222; t.g = 2; t.k = 1;
    run_instr(t);
    t.g = 0; t.r = 3; t.k = 2;
    run_instr(t);
    // lw 0x4002: misaligned under MISALIGN_EXP_EN, otherwise issued with lane shift
    t = blank(); t.re = 1'b1; t.addr = 32'h0000_4002; t.rdata = 32'hCAFE_F00D; t.req_rf = 1'b1;
    t.exp_rd = load_model(t.rdata, t.addr, t.mask);
    run_instr(t);

    // reset while waiting, then a stale rvalid after release
    t = blank(); t.re = 1'b1; t.addr = 32'h0000_0100; t.req_rf = 1'b1; t.rdata = 32'h5555_AAAA;
    t.exp_rd = 32'h5555_AAAA;
    cyc_begin();
    apply(t, 1'b1, 1'b1, 1'b0, 1'b0);
    e_req = 1'b1; e_stall = 1'b1; e_rf = 1'b0; e_flag = 1'b0; e_mis = 1'b0;
    cyc_begin();
    rst = 1'b1;
    apply(t, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_quiet();
    cyc_begin();
    rst = 1'b0;
    apply(t, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(t);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) run_idle();
      else                           run_instr(rand_instr());
    end

    cyc_begin();
    exp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
